// File: rtl/i2c_master_controller.sv
// Single-byte I2C master. It generates START, then sends the 7-bit address with R/W,
// transfers one data byte, and finishes with STOP on open-drain sda/scl lines.
module i2c_master_controller #(
    parameter int unsigned DIV = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ready,
    output logic       done,
    output logic       ack_err,
    inout  wire        sda,
    inout  wire        scl
);

    localparam int unsigned CNT_W = $clog2(DIV);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WDATA,
        S_WACK,
        S_RDATA,
        S_RACK,
        S_STOP
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         qtr_q;
    logic [2:0]         bit_cnt_q;
    logic [7:0]         addr_rw_q;
    logic [7:0]         wdata_q;
    logic [7:0]         rdata_q;
    logic               ready_q;
    logic               done_q;
    logic               ack_err_q;
    logic               sda_low_q;
    logic               scl_low_q;
    logic [1:0]         sda_sync_q;
    logic               sda_low_c;
    logic               scl_low_c;
    logic               tick_c;
    logic               sda_s;

    assign tick_c = (state_q != S_IDLE) && (cnt_q == CNT_W'(DIV - 1));
    assign sda_s  = sda_sync_q[1];

    // Line levels for the current quarter; registered below so the pins are glitch-free.
    always_comb begin
        sda_low_c = 1'b0;
        scl_low_c = 1'b0;
        case (state_q)
            S_START: begin
                sda_low_c = qtr_q[1];
                scl_low_c = (qtr_q == 2'd3);
            end
            S_ADDR: begin
                sda_low_c = ~addr_rw_q[bit_cnt_q];
                scl_low_c = ~qtr_q[1];
            end
            S_WDATA: begin
                sda_low_c = ~wdata_q[bit_cnt_q];
                scl_low_c = ~qtr_q[1];
            end
            S_ADDR_ACK, S_WACK, S_RDATA, S_RACK: begin
                scl_low_c = ~qtr_q[1];
            end
            S_STOP: begin
                sda_low_c = ~qtr_q[1];
                scl_low_c = (qtr_q == 2'd0);
            end
            default: begin
                sda_low_c = 1'b0;
                scl_low_c = 1'b0;
            end
        endcase
    end

    // Transaction sequencer; the phase advances at the end of each bit's fourth quarter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            qtr_q      <= 2'd0;
            bit_cnt_q  <= 3'd7;
            addr_rw_q  <= 8'h00;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            sda_low_q  <= 1'b0;
            scl_low_q  <= 1'b0;
            sda_sync_q <= 2'b11;
        end else begin
            done_q     <= 1'b0;
            sda_low_q  <= sda_low_c;
            scl_low_q  <= scl_low_c;
            sda_sync_q <= {sda_sync_q[0], sda};
            if (state_q == S_IDLE) begin
                cnt_q <= '0;
                qtr_q <= 2'd0;
                if (start && ready_q) begin
                    addr_rw_q <= {addr, rw};
                    wdata_q   <= wdata;
                    ack_err_q <= 1'b0;
                    ready_q   <= 1'b0;
                    bit_cnt_q <= 3'd7;
                    state_q   <= S_START;
                end
            end else if (!tick_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
                qtr_q <= qtr_q + 2'd1;
                if (qtr_q == 2'd3) begin
                    case (state_q)
                        S_START: state_q <= S_ADDR;
                        S_ADDR: begin
                            if (bit_cnt_q == 3'd0) state_q <= S_ADDR_ACK;
                            else bit_cnt_q <= bit_cnt_q - 3'd1;
                        end
                        S_ADDR_ACK: begin
                            if (sda_s) begin
                                ack_err_q <= 1'b1;
                                state_q   <= S_STOP;
                            end else begin
                                bit_cnt_q <= 3'd7;
                                state_q   <= addr_rw_q[0] ? S_RDATA : S_WDATA;
                            end
                        end
                        S_WDATA: begin
                            if (bit_cnt_q == 3'd0) state_q <= S_WACK;
                            else bit_cnt_q <= bit_cnt_q - 3'd1;
                        end
                        S_WACK: begin
                            if (sda_s) ack_err_q <= 1'b1;
                            state_q <= S_STOP;
                        end
                        S_RDATA: begin
                            rdata_q[bit_cnt_q] <= sda_s;
                            if (bit_cnt_q == 3'd0) state_q <= S_RACK;
                            else bit_cnt_q <= bit_cnt_q - 3'd1;
                        end
                        S_RACK: state_q <= S_STOP;
                        S_STOP: begin
                            state_q   <= S_IDLE;
                            done_q    <= 1'b1;
                            ready_q   <= 1'b1;
                            bit_cnt_q <= 3'd7;
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign sda     = sda_low_q ? 1'b0 : 1'bz;
    assign scl     = scl_low_q ? 1'b0 : 1'bz;
    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;

endmodule

// File: doc/i2c_master_controller.md
Name: i2c_master_controller

Overview:
- Single-byte I2C master. Generates SCL, START/STOP conditions and the address phase, then writes one byte to, or reads one byte from, a 7-bit addressed slave on a shared open-drain bus.
- Sits between a local control interface (start pulse, address, data) and the sda/scl pins. It is the initiator counterpart to the team's i2c_slave_controller.
- Standard-mode only. No clock stretching, no multi-master arbitration, no repeated START.

Parameters:
- DIV, 125, clk cycles per SCL quarter-period. Full SCL period = 4*DIV clk cycles. Legal range 2..65535.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse. Sampled only while ready=1.
- addr  input  7  slave address. Captured on an accepted start.
- rw  input  1  0 = write, 1 = read. Captured on an accepted start.
- wdata  input  8  write byte. Captured on an accepted start.
- rdata  output  8  byte read from the slave. Valid from done until the next accepted start.
- ready  output  1  1 when IDLE and able to accept start.
- done  output  1  one-clk pulse at the end of the transaction (after STOP).
- ack_err  output  1  set at done if the slave NACKed the address or the write byte. Cleared on the next accepted start.
- sda  inout  1  open-drain: driven 0 or released (z).
- scl  inout  1  open-drain: driven 0 or released (z). The bench provides pull-ups.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, sda and scl released, ready=1, done=0, ack_err=0, rdata=8'h00, quarter counter=0, bit counter=7.
- Quarter tick: a free-running counter 0..DIV-1, active outside IDLE only. A tick occurs when it wraps. All bus-level changes happen on ticks.
- Each data/ack bit occupies 4 quarters:
  - q0: scl low; sda updated.
  - q1: scl low.
  - q2: scl released (high).
  - q3: scl high; the receiver samples sda at the end of q3.
- Accept: start=1 with ready=1 captures addr, rw and wdata, clears ack_err, drops ready the next cycle, and enters START.
- START: 4 quarters.
  - q0 and q1: sda released, scl released.
  - q2: sda low while scl high.
  - q3: scl low.
- ADDR: 8 bits, MSB first: {addr, rw}. Bit counter runs 7 down to 0.
- ADDR_ACK: master releases sda and samples it in q3.
  - Sampled 1: set ack_err, go to STOP.
  - Sampled 0: reset bit counter to 7; go to WDATA if rw=0, RDATA if rw=1.
- WDATA: 8 bits of wdata, MSB first, then WACK. WACK samples the slave ACK; a sampled 1 sets ack_err. Both outcomes go to STOP.
- RDATA: sda released. The sample at each q3 shifts into rdata[bit counter], 7 down to 0.
- RACK: master drives sda=1 (released) as NACK to end the read, then goes to STOP.
- STOP: 4 quarters.
  - q0: scl low, sda low.
  - q1: scl released.
  - q2: sda released while scl high.
  - q3: idle hold.
  - Then done=1 for one clk, and the block enters IDLE with ready=1.
- Latency from accepted start to done:
  - Full transaction: 80*DIV clk cycles, ±1 clk.
  - Address NACK: 44*DIV clk cycles, ±1 clk.
- sda changes only while scl is low, except in START q2 and STOP q2.
- start while ready=0 is ignored and has no side effects.
- Address NACK: the data phase is skipped; rdata is unchanged.
- rst_n asserted mid-transaction: both lines are released immediately (asynchronous) and state returns to IDLE. No STOP is generated, and no done pulse is produced.
- The last bit of any byte flows to the ACK phase with no extra idle quarter.

Test Plan:
- DIV=4. Write addr=7'h2A, wdata=8'hA5. Bench slave ACKs both bytes. -> Bus shows START, 8'h54, ACK, 8'hA5, ACK, STOP. done after 320±1 clks; ack_err=0.
- DIV=4. Read addr=7'h2A. Slave returns 8'hCC. -> Address byte 8'h55; master NACKs the data byte; rdata=8'hCC at done; ack_err=0.
- DIV=4. addr=7'h11, no slave responds. -> ack_err=1; STOP follows the address ACK slot; done at 176±1 clks; rdata unchanged.
- Write with the slave NACKing only the data byte. -> ack_err=1, done asserted. Next start with a good transaction clears ack_err to 0.
- Assert rst_n low during bit 3 of the data byte. -> sda and scl released within the same cycle; ready=1 after reset; no done pulse.
- Pulse start while busy. -> Ignored: captured addr/wdata unchanged and a single done pulse. Protocol checker asserts sda is stable while scl is high, except at START/STOP.
